tfhe_pu_csr_axil: RTL

// - AXI4-Lite responder for the host control path: PCIe host (initiator, via the block-design AXI-Lite master) reads/writes CSRs.
// - Drives status LEDs, start pulse and HBM base address to the TFHE processing core; reports core busy/done back to the host.
// - Sits between the block-design AXI-Lite master port and the core control inputs in the tfhe_pu top level.

---
 rtl/tfhe_pu_pkg.sv | 20 ++
 rtl/tfhe_pu_csr_wr_join.sv | 60 ++++++
 rtl/tfhe_pu_csr_axil.sv | 117 +++++++++++
 3 files changed

// File: rtl/tfhe_pu_pkg.sv
// tfhe_pu_pkg: CSR map offsets, AXI response codes and STATUS bit positions
package tfhe_pu_pkg;
    localparam logic [31:0] CSR_ID      = 32'h00;
    localparam logic [31:0] CSR_CTRL    = 32'h04;
    localparam logic [31:0] CSR_STATUS  = 32'h08;
    localparam logic [31:0] CSR_LED     = 32'h0C;
    localparam logic [31:0] CSR_SCRATCH = 32'h10;
    localparam logic [31:0] CSR_BASE_LO = 32'h14;
    localparam logic [31:0] CSR_BASE_HI = 32'h18;
    localparam logic [31:0] CSR_CYCLES  = 32'h1C;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/tfhe_pu_csr_wr_join.sv
// tfhe_pu_csr_wr_join: holds AW and W independently and joins them into one commit strobe plus B handshake
module tfhe_pu_csr_wr_join #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic [3:0]        strb
);
    logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d, b_done;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0] strb_q, strb_d;
    assign awready = !aw_held_q;
    assign wready  = !w_held_q;
    assign bvalid  = bvalid_q;
    assign addr    = addr_q;
    assign data    = data_q;
    assign strb    = strb_q;
    // holding regs stay full until the B handshake so a new write cannot start early
    always_comb begin
        b_done    = bvalid_q && bready;
        commit    = aw_held_q && w_held_q && !bvalid_q;
        aw_held_d = aw_held_q ? !b_done : awvalid;
        w_held_d  = w_held_q ? !b_done : wvalid;
        addr_d    = (awvalid && !aw_held_q) ? awaddr : addr_q;
        data_d    = (wvalid && !w_held_q) ? wdata : data_q;
        strb_d    = (wvalid && !w_held_q) ? wstrb : strb_q;
        bvalid_d  = commit || (bvalid_q && !bready);
    end
    // channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end
endmodule

// File: rtl/tfhe_pu_csr_axil.sv
// tfhe_pu_csr_axil: AXI4-Lite CSR block driving TFHE core control, LEDs and HBM base address
module tfhe_pu_csr_axil #(
    parameter int          ADDR_W   = 12,
    parameter int          LED_W    = 8,
    parameter logic [31:0] ID_VALUE = 32'h7FE5_0001
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [LED_W-1:0]  leds,
    output logic              core_start,
    input  logic              core_busy,
    input  logic              core_done,
    output logic [63:0]       hbm_base
);
    import tfhe_pu_pkg::*;
    logic commit;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0] w_data;
    logic [3:0] w_strb;
    tfhe_pu_csr_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
        .clk(sys_clk), .rst(sys_rst),
        .awaddr(s_axil_awaddr), .awvalid(s_axil_awvalid), .awready(s_axil_awready),
        .wdata(s_axil_wdata), .wstrb(s_axil_wstrb), .wvalid(s_axil_wvalid), .wready(s_axil_wready),
        .bvalid(s_axil_bvalid), .bready(s_axil_bready),
        .commit(commit), .addr(w_addr), .data(w_data), .strb(w_strb)
    );
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0] scratch_q, scratch_d, lo_q, lo_d, hi_q, hi_d, cycles_q, cycles_d, rdata_q, rdata_d;
    logic done_q, done_d, start_q, start_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] wa, ra, status, rd_val, led_m;
    logic wr_ok, rd_ok, ar_hs, w1c;
    assign s_axil_arready = !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_bresp   = bresp_q;
    assign leds           = led_q;
    assign core_start     = start_q;
    assign hbm_base       = {hi_q, lo_q};
    // decode, CSR next-state and read mux; reads see pre-write register values
    always_comb begin
        wa       = 32'(w_addr) & ~32'h3;
        ra       = 32'(s_axil_araddr) & ~32'h3;
        wr_ok    = wa == CSR_CTRL || wa == CSR_STATUS || wa == CSR_LED || wa == CSR_SCRATCH || wa == CSR_BASE_LO || wa == CSR_BASE_HI;
        rd_ok    = ra <= CSR_CYCLES;
        status   = '0;
        status[STATUS_BUSY] = core_busy;
        status[STATUS_DONE] = done_q;
        rd_val   = ra == CSR_ID      ? ID_VALUE :
                   ra == CSR_STATUS  ? status :
                   ra == CSR_LED     ? 32'(led_q) :
                   ra == CSR_SCRATCH ? scratch_q :
                   ra == CSR_BASE_LO ? lo_q :
                   ra == CSR_BASE_HI ? hi_q :
                   ra == CSR_CYCLES  ? cycles_q : 32'h0;
        led_m     = merge_strb(32'(led_q), w_data, w_strb);
        led_d     = (commit && wa == CSR_LED) ? led_m[LED_W-1:0] : led_q;
        scratch_d = (commit && wa == CSR_SCRATCH) ? merge_strb(scratch_q, w_data, w_strb) : scratch_q;
        lo_d      = (commit && wa == CSR_BASE_LO) ? merge_strb(lo_q, w_data, w_strb) : lo_q;
        hi_d      = (commit && wa == CSR_BASE_HI) ? merge_strb(hi_q, w_data, w_strb) : hi_q;
        start_d   = commit && wa == CSR_CTRL && w_strb[0] && w_data[0];
        w1c       = commit && wa == CSR_STATUS && w_strb[0] && w_data[STATUS_DONE];
        done_d    = core_done || (done_q && !w1c);
        cycles_d  = start_q ? 32'h0 : (core_busy && cycles_q != 32'hFFFF_FFFF) ? cycles_q + 32'h1 : cycles_q;
        bresp_d   = commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        ar_hs     = s_axil_arvalid && !rvalid_q;
        rdata_d   = ar_hs ? rd_val : rdata_q;
        rresp_d   = ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
        rvalid_d  = ar_hs || (rvalid_q && !s_axil_rready);
    end
    // CSR and read-channel registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_q     <= '0;
            scratch_q <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            led_q     <= led_d;
            scratch_q <= scratch_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            cycles_q  <= cycles_d;
            done_q    <= done_d;
            start_q   <= start_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule
